// File: rtl/fifo_rd_ctrl_fwft.sv
// Async FIFO read side: Gray pointer sync, RAM read addressing, 2-entry FWFT buffer.
// Define FIFO_RD_LEVEL_EN to add the registered RD_LEVEL occupancy output.
module fifo_rd_ctrl_fwft #(
    parameter int C_RAM_WIDTH   = 32,
    parameter int C_RAM_DEPTH   = 1024,
    parameter int C_SYNC_STAGES = 2,
    localparam int A = $clog2(C_RAM_DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [A:0]             WR_PTR_GRAY,
    output logic [A:0]             RD_PTR_GRAY,
    output logic [A-1:0]           RAM_ADDRB,
    input  logic [C_RAM_WIDTH-1:0] RAM_DOUTB,
    output logic [C_RAM_WIDTH-1:0] RD_DATA,
    output logic                   RD_VALID,
    input  logic                   RD_READY,
    output logic                   RD_EMPTY
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [A+1:0]           RD_LEVEL
`endif
);

    logic [A:0]             sync_q [C_SYNC_STAGES];
    logic [A:0]             wr_bin_s;
    logic [A:0]             rd_bin;
    logic [A:0]             rd_bin_nxt;
    logic                   inflight;
    logic                   ram_avail;
    logic                   pop;
    logic                   push;
    logic                   fetch;
    logic [2:0]             occ;
    logic [C_RAM_WIDTH-1:0] buf_mem [2];
    logic                   head;
    logic                   tail;
    logic [1:0]             buf_cnt;

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= WR_PTR_GRAY;
            for (int i = 1; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_bin_s   = gray2bin(sync_q[C_SYNC_STAGES-1]);
    assign ram_avail  = (wr_bin_s != rd_bin);
    assign rd_bin_nxt = rd_bin + (A+1)'(1);

    assign RD_VALID = (buf_cnt != 2'd0);
    assign RD_EMPTY = (buf_cnt == 2'd0);
    assign pop      = RD_VALID & RD_READY;
    assign push     = inflight;

    // Credit: buffered + in-flight words after this cycle's pop must leave room.
    assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fetch = ram_avail && (occ < 3'd2);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_bin      <= '0;
            RD_PTR_GRAY <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= fetch;
            if (fetch) begin
                rd_bin      <= rd_bin_nxt;
                RD_PTR_GRAY <= bin2gray(rd_bin_nxt);
            end
        end
    end

    assign RAM_ADDRB = rd_bin[A-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[tail] <= RAM_DOUTB;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            unique case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign RD_DATA = buf_mem[head];

`ifdef FIFO_RD_LEVEL_EN
    logic [A:0]   ram_words;
    logic [A+1:0] level_nxt;

    assign ram_words = wr_bin_s - rd_bin;
    assign level_nxt = {1'b0, ram_words} + {{A{1'b0}}, buf_cnt}
                     + {{(A+1){1'b0}}, inflight};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_LEVEL <= '0;
        end else begin
            RD_LEVEL <= level_nxt;
        end
    end
`endif

endmodule
